// File: rtl/kfps2_pkg.sv
// Shared types, parity helper and command constants for the PS/2 keyboard host logic.
package kfps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    RELEASE
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/kfps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins with falling-edge detect on each.
module kfps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic device_clock,
  input  logic device_data,
  output logic clock_sync,
  output logic data_sync,
  output logic clock_fall,
  output logic data_fall
);

  logic [1:0] clock_stage_q;
  logic [1:0] data_stage_q;
  logic       clock_prev_q;
  logic       data_prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clock_stage_q <= 2'b11;
      data_stage_q  <= 2'b11;
      clock_prev_q  <= 1'b1;
      data_prev_q   <= 1'b1;
    end else begin
      clock_stage_q <= {clock_stage_q[0], device_clock};
      data_stage_q  <= {data_stage_q[0], device_data};
      clock_prev_q  <= clock_stage_q[1];
      data_prev_q   <= data_stage_q[1];
    end
  end

  assign clock_sync = clock_stage_q[1];
  assign data_sync  = data_stage_q[1];
  assign clock_fall = clock_prev_q & ~clock_stage_q[1];
  assign data_fall  = data_prev_q & ~data_stage_q[1];

endmodule

// File: rtl/kfps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out frame, ack check.
module kfps2_host_transmitter
  import kfps2_pkg::*;
#(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd5000,
  parameter logic [23:0] RTS_TIMEOUT    = 24'd750000,
  parameter logic [15:0] BIT_TIMEOUT    = 16'd1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_drive_low,
  output logic       device_data_drive_low,
  input  logic       tx_request,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  localparam logic [23:0] INHIBIT_LAST = {8'd0, INHIBIT_CYCLES} - 24'd1;
  localparam logic [23:0] RTS_LAST     = RTS_TIMEOUT - 24'd1;
  localparam logic [23:0] BIT_LAST     = {8'd0, BIT_TIMEOUT} - 24'd1;

  ps2_tx_state_t state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   timer_q, timer_d;
  logic          data_low_q, data_low_d;

  logic clock_sync;
  logic data_sync;
  logic clock_fall;

  kfps2_line_sync u_line_sync (
    .clock        (clock),
    .reset        (reset),
    .device_clock (device_clock),
    .device_data  (device_data),
    .clock_sync   (clock_sync),
    .data_sync    (data_sync),
    .clock_fall   (clock_fall),
    .data_fall    ()
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      data_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      data_low_q <= data_low_d;
    end
  end

  // Result pulses are issued in the last non-IDLE cycle, so tx_ready rises the cycle after.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q + 24'd1;
    data_low_d = data_low_q;
    tx_done    = 1'b0;
    tx_error   = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d    = '0;
        data_low_d = 1'b0;
        if (tx_request) begin
          shift_d = {1'b1, odd_parity(tx_data), tx_data};
          state_d = INHIBIT;
        end
      end

      // Device falls cannot end the inhibit early; it always runs the full count.
      INHIBIT: begin
        if (timer_q == INHIBIT_LAST) begin
          state_d    = RTS;
          timer_d    = '0;
          bit_cnt_d  = '0;
          data_low_d = 1'b1;
        end
      end

      RTS: begin
        if (clock_fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = {1'b1, shift_q[9:1]};
          bit_cnt_d  = 4'd1;
          timer_d    = '0;
          state_d    = SEND;
        end else if (timer_q == RTS_LAST) begin
          tx_error   = 1'b1;
          data_low_d = 1'b0;
          state_d    = IDLE;
        end
      end

      // bit_cnt counts falls since RTS; the 11th fall follows the stop bit.
      SEND: begin
        if (clock_fall) begin
          timer_d = '0;
          if (bit_cnt_q == 4'd10) begin
            data_low_d = 1'b0;
            state_d    = ACK;
          end else begin
            data_low_d = ~shift_q[0];
            shift_d    = {1'b1, shift_q[9:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end else if (timer_q == BIT_LAST) begin
          tx_error   = 1'b1;
          data_low_d = 1'b0;
          state_d    = IDLE;
        end
      end

      ACK: begin
        if (clock_fall) begin
          timer_d = '0;
          if (data_sync) begin
            tx_error = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = RELEASE;
          end
        end else if (timer_q == BIT_LAST) begin
          tx_error = 1'b1;
          state_d  = IDLE;
        end
      end

      RELEASE: begin
        if (clock_fall) begin
          timer_d = '0;
        end
        if (clock_sync && data_sync) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end else if (!clock_fall && timer_q == BIT_LAST) begin
          tx_error = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        data_low_d = 1'b0;
      end
    endcase
  end

  assign device_clock_drive_low = (state_q == INHIBIT);
  assign device_data_drive_low  = data_low_q;
  assign tx_ready               = (state_q == IDLE);
  assign rx_inhibit             = (state_q != IDLE);

endmodule

// File: tb/tb_kfps2_host_transmitter.sv
// Bench for kfps2_host_transmitter: open-drain line model, device model and frame-level reference.
module tb_kfps2_host_transmitter;

  localparam int INHIBIT = 40;
  localparam int RTS_TO  = 1500;
  localparam int BIT_TO  = 150;

  logic       clock;
  logic       reset;
  logic       device_clock;
  logic       device_data;
  logic       device_clock_drive_low;
  logic       device_data_drive_low;
  logic       tx_request;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;

  logic dev_clk;
  logic dev_data;

  int vectors    = 0;
  int miscompares = 0;
  int n_done     = 0;
  int n_err      = 0;
  bit busy       = 1'b0;
  int clow_run   = 0;

  // Open-drain wired-AND between host and device.
  assign device_clock = dev_clk & ~device_clock_drive_low;
  assign device_data  = dev_data & ~device_data_drive_low;

  kfps2_host_transmitter #(
    .INHIBIT_CYCLES (16'(INHIBIT)),
    .RTS_TIMEOUT    (24'(RTS_TO)),
    .BIT_TIMEOUT    (16'(BIT_TO))
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .device_clock           (device_clock),
    .device_data            (device_data),
    .device_clock_drive_low (device_clock_drive_low),
    .device_data_drive_low  (device_data_drive_low),
    .tx_request             (tx_request),
    .tx_data                (tx_data),
    .tx_ready               (tx_ready),
    .tx_done                (tx_done),
    .tx_error               (tx_error),
    .rx_inhibit             (rx_inhibit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit i = i-th bit on the wire).
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  // Per-cycle compare against the busy/idle model and inhibit-length rule.
  always @(negedge clock) begin
    if (reset) begin
      busy     = 1'b0;
      clow_run = 0;
    end else begin
      check("tx_ready", tx_ready, !busy);
      check("rx_inhibit", rx_inhibit, busy);
      if (device_clock_drive_low) begin
        clow_run++;
      end else if (clow_run != 0) begin
        check("inhibit_len", clow_run, INHIBIT);
        check("rts_data_low", device_data_drive_low, 1);
        clow_run = 0;
      end
      if (tx_done || tx_error) begin
        check("pulse_when_busy", busy, 1);
        check("single_pulse", tx_done & tx_error, 0);
        n_done += int'(tx_done);
        n_err  += int'(tx_error);
        busy = 1'b0;
      end else if (!busy && tx_request) begin
        busy = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send_request(input logic [7:0] d);
    check("ready_before_req", tx_ready, 1);
    tx_data    = d;
    tx_request = 1'b1;
    tick();
    tx_request = 1'b0;
  endtask

  task automatic device_frame(input int half, input int nfalls, input int req_at,
                              output logic [10:0] bits);
    int t;
    bits = '0;
    t    = 0;
    while (!(device_data_drive_low && !device_clock_drive_low) && t < 5000) begin
      tick();
      t++;
    end
    check("rts_seen", 32'(t < 5000), 1);
    repeat (10) tick();
    bits[0] = device_data;
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk = 1'b0;
      repeat (half) tick();
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = device_data;
      if (i == req_at) begin
        tx_data    = 8'h00;
        tx_request = 1'b1;
        tick();
        tx_request = 1'b0;
      end
      repeat (half) tick();
    end
  endtask

  task automatic device_ack(input int half, input logic ack, output int lat);
    lat      = -1;
    dev_data = ack;
    repeat (half) tick();
    dev_clk = 1'b0;
    for (int k = 1; k <= half; k++) begin
      tick();
      if (tx_error && lat < 0) lat = k;
    end
    dev_clk = 1'b1;
    repeat (half) tick();
    dev_data = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!tx_ready && t < 300) begin
      tick();
      t++;
    end
    check("return_idle", tx_ready, 1);
  endtask

  task automatic full_frame(input logic [7:0] d, input int half, input logic ack,
                            output logic [10:0] bits);
    int lat;
    send_request(d);
    device_frame(half, 11, 0, bits);
    device_ack(half, ack, lat);
    wait_idle();
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  d;
    int          d0, e0, cnt, lat, half;
    logic        ack;

    reset      = 1'b1;
    dev_clk    = 1'b1;
    dev_data   = 1'b1;
    tx_request = 1'b0;
    tx_data    = 8'h00;
    repeat (3) tick();
    check("rst_clk_low", device_clock_drive_low, 0);
    check("rst_data_low", device_data_drive_low, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_done_err", {tx_done, tx_error}, 0);
    check("rst_inhibit", rx_inhibit, 0);
    reset = 1'b0;
    repeat (3) tick();

    // Enable command, pinned against hand-computed wire bits.
    d0 = n_done; e0 = n_err;
    full_frame(8'hF4, 20, 1'b0, bits);
    check("f4_frame", bits, 11'h5E8);
    check("f4_done", n_done - d0, 1);
    check("f4_err", n_err - e0, 0);

    d0 = n_done; e0 = n_err;
    full_frame(8'hED, 12, 1'b0, bits);
    check("ed_frame", bits, 11'h7DA);
    full_frame(8'hFF, 25, 1'b0, bits);
    check("ff_frame", bits, 11'h7FE);
    check("ed_ff_done", n_done - d0, 2);
    check("ed_ff_err", n_err - e0, 0);

    // Silent device: request-to-send must time out.
    d0 = n_done; e0 = n_err;
    send_request(8'hF4);
    cnt = 0;
    while (!(device_data_drive_low && !device_clock_drive_low) && cnt < 500) begin
      tick();
      cnt++;
    end
    cnt = 1;
    while (!tx_error && cnt < RTS_TO + 50) begin
      tick();
      cnt++;
    end
    check("rts_timeout_cycles", cnt, RTS_TO);
    tick();
    check("rts_to_clk_rel", device_clock_drive_low, 0);
    check("rts_to_data_rel", device_data_drive_low, 0);
    check("rts_to_inhibit", rx_inhibit, 0);
    check("rts_to_err", n_err - e0, 1);

    // Device stalls after the 5th fall.
    d0 = n_done; e0 = n_err;
    send_request(8'h5A);
    device_frame(15, 4, 0, bits);
    dev_clk = 1'b0;
    cnt = 0;
    while (!tx_error && cnt < BIT_TO + 50) begin
      tick();
      cnt++;
      if (cnt == 15) dev_clk = 1'b1;
    end
    check("bit_timeout_cycles", cnt, BIT_TO + 2);
    wait_idle();
    check("bit_to_done", n_done - d0, 0);
    check("bit_to_err", n_err - e0, 1);

    // Ack bit 1 with an ignored second request mid-frame.
    d0 = n_done; e0 = n_err;
    send_request(8'h3C);
    device_frame(15, 11, 6, bits);
    check("nack_frame", bits, frame_model(8'h3C));
    device_ack(15, 1'b1, lat);
    check("nack_latency", lat, 2);
    wait_idle();
    repeat (INHIBIT + 10) tick();
    check("nack_clk_idle", device_clock_drive_low, 0);
    check("nack_done", n_done - d0, 0);
    check("nack_err", n_err - e0, 1);

    // Reset mid-frame while D3 = 0 is driven.
    d0 = n_done; e0 = n_err;
    send_request(8'h00);
    device_frame(15, 4, 0, bits);
    check("pre_rst_data_low", device_data_drive_low, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_data_rel", device_data_drive_low, 0);
    check("mid_rst_clk_rel", device_clock_drive_low, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("mid_rst_pulses", (n_done - d0) + (n_err - e0), 0);
    full_frame(8'hFF, 15, 1'b0, bits);
    check("post_rst_frame", bits, frame_model(8'hFF));
    check("post_rst_done", n_done - d0, 1);

    // Randomised commands, clock rates and ack values.
    for (int r = 0; r < 8; r++) begin
      d    = 8'($urandom);
      half = $urandom_range(8, 40);
      ack  = 1'($urandom_range(0, 1));
      d0 = n_done; e0 = n_err;
      full_frame(d, half, ack, bits);
      check("rand_frame", bits, frame_model(d));
      check("rand_done", n_done - d0, ack ? 0 : 1);
      check("rand_err", n_err - e0, ack ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
